// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one off-chip memory port between the I-cache and D-cache.
// A grantee is picked in IDLE. Its address, op and write word are latched.
// The memory strobes are held for LATENCY cycles. Read data is captured into
// the grantee's data register, and a one-cycle done pulse is returned.
//
// State table
//   state  | meaning
//   IDLE   | no access in flight; arbitrate and latch the next request
//   ACCESS | readM/writeM high; counter runs down to the capture edge
//   DONE   | strobes low; grantee's done pulse high for this cycle
//
// Ports
//   clk, reset_n              system clock, async active-low reset
//   i_readM, i_address        I-cache read request (level) and address
//   i_data, i_done            block returned to I-cache, completion pulse
//   d_readM, d_writeM         D-cache read / write requests (level)
//   d_address, d_wdata        D-cache address and write word
//   d_data, d_done            block returned to D-cache, completion pulse
//   readM, writeM, address    memory strobes and address
//   data                      bidirectional memory data bus
//   busy                      high whenever an access is in flight
module mem_arbiter #(
   parameter int unsigned LATENCY = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_readM,
   input  logic [15:0] i_address,
   output logic [63:0] i_data,
   output logic        i_done,
   input  logic        d_readM,
   input  logic        d_writeM,
   input  logic [15:0] d_address,
   input  logic [15:0] d_wdata,
   output logic [63:0] d_data,
   output logic        d_done,
   output logic        readM,
   output logic        writeM,
   output logic [15:0] address,
   inout  wire  [63:0] data,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state, next_state;
   logic [7:0]  cnt;
   logic [15:0] lat_addr;
   logic [15:0] lat_wdata;
   logic        lat_write;
   logic        grant_d;
   logic        last_grant_d;

   logic i_req, d_req, any_req, pick_d;

   assign i_req   = i_readM;
   assign d_req   = d_readM | d_writeM;
   assign any_req = i_req | d_req;
   // On a tie the requester not served last wins; reset value favours D first.
   assign pick_d  = d_req & (~i_req | ~last_grant_d);

   assign address = lat_addr;

   // Only the low word is ever driven; the upper bus stays released.
   assign data[15:0]  = writeM ? lat_wdata : {16{1'bz}};
   assign data[63:16] = {48{1'bz}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      readM      = 1'b0;
      writeM     = 1'b0;
      i_done     = 1'b0;
      d_done     = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_req) next_state = ACCESS;
         end
         ACCESS: begin
            readM  = ~lat_write;
            writeM = lat_write;
            if (cnt == 8'd0) next_state = DONE;
         end
         DONE: begin
            i_done     = ~grant_d;
            d_done     = grant_d;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= 8'd0;
         lat_addr     <= 16'd0;
         lat_wdata    <= 16'd0;
         lat_write    <= 1'b0;
         grant_d      <= 1'b0;
         last_grant_d <= 1'b0;
         i_data       <= 64'd0;
         d_data       <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_d   <= pick_d;
                  lat_addr  <= pick_d ? d_address : i_address;
                  // A D-cache request with both strobes high is a write.
                  lat_write <= pick_d & d_writeM;
                  lat_wdata <= pick_d ? d_wdata : 16'd0;
                  cnt       <= 8'(LATENCY - 1);
               end
            end
            ACCESS: begin
               if (cnt == 8'd0) begin
                  last_grant_d <= grant_d;
                  if (!lat_write) begin
                     if (grant_d) d_data <= data;
                     else         i_data <= data;
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_readM = 1'b0;
   logic [15:0] i_address = 16'd0;
   logic [63:0] i_data;
   logic        i_done;
   logic        d_readM = 1'b0;
   logic        d_writeM = 1'b0;
   logic [15:0] d_address = 16'd0;
   logic [15:0] d_wdata = 16'd0;
   logic [63:0] d_data;
   logic        d_done;
   logic        readM;
   logic        writeM;
   logic [15:0] address;
   wire  [63:0] data;
   logic        busy;

   mem_arbiter #(.LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_done(i_done),
      .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address),
      .d_wdata(d_wdata), .d_data(d_data), .d_done(d_done),
      .readM(readM), .writeM(writeM), .address(address), .data(data), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mem_word(input logic [15:0] a);
      if (a == 16'h0040) return 64'h0123_4567_89AB_CDEF;
      return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
   endfunction

   // Memory model: drives the bus only while a read strobe is up.
   assign data = readM ? mem_word(address) : {64{1'bz}};

   typedef struct {
      logic        is_d;
      logic        is_wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [63:0] exp_i;
      logic [63:0] exp_d;
      logic        b2b;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] mdl_i = 64'd0;
   logic [63:0] mdl_d = 64'd0;
   logic        mdl_last_d = 1'b0;
   logic        stray_ok = 1'b0;
   int          cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic is_d, input logic is_wr, input logic [15:0] a,
                       input logic [15:0] w, input logic b2b);
      exp_t e;
      if (!is_wr) begin
         if (is_d) mdl_d = mem_word(a);
         else      mdl_i = mem_word(a);
      end
      mdl_last_d = is_d;
      e.is_d = is_d; e.is_wr = is_wr; e.addr = a; e.wdata = w;
      e.exp_i = mdl_i; e.exp_d = mdl_d; e.b2b = b2b;
      sb.push_back(e);
   endtask

   task automatic wait_done(input logic is_d);
      int n = 0;
      logic seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         seen = is_d ? d_done : i_done;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout waiting for %s done", is_d ? "d" : "i");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic req_i(input logic [15:0] a);
      @(posedge clk); #1;
      i_address = a; i_readM = 1'b1;
      wait_done(1'b0);
      i_readM = 1'b0;
   endtask

   task automatic req_d(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] w);
      @(posedge clk); #1;
      d_address = a; d_wdata = w; d_readM = rd; d_writeM = wr;
      wait_done(1'b1);
      d_readM = 1'b0; d_writeM = 1'b0;
   endtask

   // Simultaneous I and D reads: order follows the round-robin model.
   task automatic pair(input logic [15:0] ia, input logic [15:0] da);
      if (!mdl_last_d) begin
         push(1'b1, 1'b0, da, 16'd0, 1'b0);
         push(1'b0, 1'b0, ia, 16'd0, 1'b1);
      end else begin
         push(1'b0, 1'b0, ia, 16'd0, 1'b0);
         push(1'b1, 1'b0, da, 16'd0, 1'b1);
      end
      fork
         req_i(ia);
         req_d(1'b1, 1'b0, da, 16'd0);
      join
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard.
   int run = 0;
   int last_rise = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         run = 0;
      end else begin
         if (readM || writeM) begin
            if (sb.size() == 0) begin
               if (!stray_ok) chk("unexpected_strobe", 64'(readM | writeM), 64'd0);
            end else begin
               if (run == 0) begin
                  if (sb[0].b2b) chk("grant_spacing", 64'(cyc - last_rise), 64'(LAT + 2));
                  last_rise = cyc;
               end
               chk("readM", 64'(readM), 64'(!sb[0].is_wr));
               chk("writeM", 64'(writeM), 64'(sb[0].is_wr));
               chk("address", 64'(address), 64'(sb[0].addr));
               chk("busy", 64'(busy), 64'd1);
               if (sb[0].is_wr) chk("wdata", 64'(data[15:0]), 64'(sb[0].wdata));
            end
            run++;
         end
         if (i_done || d_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'({i_done, d_done}), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("i_done", 64'(i_done), 64'(!e.is_d));
               chk("d_done", 64'(d_done), 64'(e.is_d));
               chk("strobe_len", 64'(run), 64'(LAT));
               chk("strobe_in_done", 64'(readM | writeM), 64'd0);
               chk("i_data", i_data, e.exp_i);
               chk("d_data", d_data, e.exp_d);
            end
            run = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_readM", 64'(readM), 64'd0);
      chk("rst_writeM", 64'(writeM), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'({i_done, d_done}), 64'd0);
      chk("rst_address", 64'(address), 64'd0);
      chk("rst_i_data", i_data, 64'd0);
      chk("rst_d_data", d_data, 64'd0);
      reset_n = 1'b1;

      push(1'b0, 1'b0, 16'h0040, 16'd0, 1'b0);
      req_i(16'h0040);
      push(1'b1, 1'b0, 16'h0100, 16'd0, 1'b0);
      req_d(1'b1, 1'b0, 16'h0100, 16'd0);
      push(1'b1, 1'b1, 16'h0013, 16'hBEEF, 1'b0);
      req_d(1'b0, 1'b1, 16'h0013, 16'hBEEF);
      push(1'b1, 1'b1, 16'h0055, 16'h1234, 1'b0);
      req_d(1'b1, 1'b1, 16'h0055, 16'h1234);

      push(1'b1, 1'b0, 16'h0010, 16'd0, 1'b0);
      fork
         req_d(1'b1, 1'b0, 16'h0010, 16'd0);
         begin
            repeat (3) @(posedge clk);
            #2 d_address = 16'h0020;
         end
      join

      // Reset in the third strobe cycle of an I read.
      stray_ok = 1'b1;
      @(posedge clk); #1;
      i_address = 16'h0040; i_readM = 1'b1;
      begin
         int hi = 0;
         int n = 0;
         while (hi < 3 && n < 50) begin
            @(negedge clk);
            n++;
            if (readM) hi++;
         end
         if (hi < 3) begin
            checks++; errors++;
            $display("FAIL timeout waiting for readM before reset");
         end
      end
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_readM", 64'(readM), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_i_data", i_data, 64'd0);
      chk("midrst_d_data", d_data, 64'd0);
      i_readM = 1'b0;
      mdl_i = 64'd0; mdl_d = 64'd0; mdl_last_d = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      stray_ok = 1'b0;

      push(1'b0, 1'b0, 16'h0040, 16'd0, 1'b0);
      req_i(16'h0040);
      pair(16'h0200, 16'h0300);
      push(1'b1, 1'b0, 16'h0400, 16'd0, 1'b0);
      req_d(1'b1, 1'b0, 16'h0400, 16'd0);
      pair(16'h0500, 16'h0600);

      begin
         int n = 0;
         while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
         end
         if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard not drained: %0d left", sb.size());
         end
      end
      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
